bus_rr_arbiter: RTL and testbench

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

---
 rtl/bus_arb_pkg.sv | 16 +
 rtl/bus_arb_id_fifo.sv | 83 ++++++++
 rtl/bus_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter.
// Contents:
//   DefaultMaxOutstanding - default number of granted-but-unanswered
//                           downstream transactions
//   clog2(n)              - width of an index into n entries, never 0,
//                           used to size host IDs and FIFO pointers
package bus_arb_pkg;

  localparam int unsigned DefaultMaxOutstanding = 2;

  // A single-entry structure still needs a 1-bit index, so clamp at 1.
  function automatic int unsigned clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// Synchronous FIFO holding the host IDs of granted, still-unanswered
// downstream transactions, oldest first.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   push_i, data_i       write an ID (ignored when full unless popping)
//   pop_i                drop the head entry (ignored when empty)
//   data_o               head entry
//   full_o, empty_o      occupancy flags
//   count_o              number of stored entries
module bus_arb_id_fifo
  import bus_arb_pkg::*;
#(
  parameter int unsigned Depth = DefaultMaxOutstanding,
  parameter int unsigned Width = 1,
  localparam int unsigned PtrW = clog2(Depth),
  localparam int unsigned CntW = clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [Width-1:0] data_i,
  input  logic            pop_i,
  output logic [Width-1:0] data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is allowed when the head leaves in the same
  // cycle, since the freed slot is exactly the one being written.
  assign doPush = push_i & (~full_o | pop_i);
  assign doPop  = pop_i & ~empty_o;

  // Pointer and occupancy bookkeeping; depth need not be a power of two,
  // so pointers wrap explicitly.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (doPush) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (doPop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (doPush && !doPop) begin
      count_d = count_q + 1'b1;
    end else if (!doPush && doPop) begin
      count_d = count_q - 1'b1;
    end
  end

  // State registers; reset empties the FIFO immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (doPush) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter multiplexing NrHosts request/grant hosts onto one
// downstream port, with in-order response routing by an ID FIFO.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   host_*_i / host_*_o    per-host request channel and response channel
//   out_*_o / out_*_i      single downstream request and response channel
//   protocol_err_o         sticky: a response arrived with nothing outstanding
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      host_req_i    [NrHosts],
  output logic                      host_gnt_o    [NrHosts],
  input  logic [AddressWidth-1:0]   host_addr_i   [NrHosts],
  input  logic                      host_we_i     [NrHosts],
  input  logic [DataWidth/8-1:0]    host_be_i     [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i  [NrHosts],
  output logic                      host_rvalid_o [NrHosts],
  output logic [DataWidth-1:0]      host_rdata_o  [NrHosts],
  output logic                      host_err_o    [NrHosts],
  output logic                      out_req_o,
  input  logic                      out_gnt_i,
  output logic [AddressWidth-1:0]   out_addr_o,
  output logic                      out_we_o,
  output logic [DataWidth/8-1:0]    out_be_o,
  output logic [DataWidth-1:0]      out_wdata_o,
  input  logic                      out_rvalid_i,
  input  logic [DataWidth-1:0]      out_rdata_i,
  input  logic                      out_err_i,
  output logic                      protocol_err_o
);

  localparam int unsigned IdW  = clog2(NrHosts);
  localparam int unsigned CntW = clog2(MaxOutstanding + 1);

  typedef logic [IdW-1:0] host_id_t;

  host_id_t        rr_ptr_q, rr_ptr_d;
  logic            lock_q, lock_d;
  host_id_t        locked_id_q, locked_id_d;
  logic            prot_err_q, prot_err_d;

  host_id_t        cand, searchSel, sel, fifoHead;
  logic            anyReq, grant, fifoPush, fifoPop, fifoFull, fifoEmpty;
  logic [CntW-1:0] count_q;

  // Round-robin search: walk from the highest offset down so the last hit
  // written is the first requester at or after rr_ptr_q.
  always_comb begin
    searchSel = rr_ptr_q;
    anyReq    = 1'b0;
    cand      = '0;
    for (int unsigned i = NrHosts; i > 0; i--) begin
      cand = host_id_t'((32'(rr_ptr_q) + i - 1) % NrHosts);
      if (host_req_i[cand]) begin
        searchSel = cand;
        anyReq    = 1'b1;
      end
    end
  end

  // A stalled request keeps its host until the downstream grants it.
  assign sel       = lock_q ? locked_id_q : searchSel;
  assign out_req_o = (anyReq | lock_q) & (count_q < CntW'(MaxOutstanding));
  assign grant     = out_req_o & out_gnt_i;
  assign fifoPush  = grant & ~fifoFull;
  assign fifoPop   = out_rvalid_i & ~fifoEmpty;

  // Request mux, grant fan-out and response routing to the head ID.
  always_comb begin
    out_addr_o  = '0;
    out_we_o    = 1'b0;
    out_be_o    = '0;
    out_wdata_o = '0;
    if (out_req_o) begin
      out_addr_o  = host_addr_i[sel];
      out_we_o    = host_we_i[sel];
      out_be_o    = host_be_i[sel];
      out_wdata_o = host_wdata_i[sel];
    end
    for (int unsigned i = 0; i < NrHosts; i++) begin
      host_gnt_o[i]    = grant && (sel == host_id_t'(i));
      host_rvalid_o[i] = fifoPop && (fifoHead == host_id_t'(i));
      host_rdata_o[i]  = host_rvalid_o[i] ? out_rdata_i : '0;
      host_err_o[i]    = host_rvalid_o[i] & out_err_i;
    end
  end

  // Arbitration state: lock on a stalled request, advance the pointer past
  // the winner on each grant, remember any response with no owner.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    prot_err_d  = prot_err_q | (out_rvalid_i & fifoEmpty);
    if (grant) begin
      lock_d   = 1'b0;
      rr_ptr_d = (sel == host_id_t'(NrHosts - 1)) ? '0 : sel + 1'b1;
    end else if (out_req_o) begin
      lock_d      = 1'b1;
      locked_id_d = sel;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      locked_id_q <= '0;
      prot_err_q  <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
      prot_err_q  <= prot_err_d;
    end
  end

  assign protocol_err_o = prot_err_q;

  bus_arb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifoPush),
    .data_i  (sel),
    .pop_i   (fifoPop),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (count_q)
  );

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Testbench for bus_rr_arbiter: directed vector tables for the named
// scenarios, then random traffic checked against a queue-based model.
module tb_bus_rr_arbiter;

  localparam int NrHosts = 2;
  localparam int MaxOut  = 2;
  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int BW      = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hostReq    [NrHosts];
  logic          hostGnt    [NrHosts];
  logic [AW-1:0] hostAddr   [NrHosts];
  logic          hostWe     [NrHosts];
  logic [BW-1:0] hostBe     [NrHosts];
  logic [DW-1:0] hostWdata  [NrHosts];
  logic          hostRvalid [NrHosts];
  logic [DW-1:0] hostRdata  [NrHosts];
  logic          hostErr    [NrHosts];
  logic          outReq, outGnt, outWe, outRvalid, outErr, protErr;
  logic [AW-1:0] outAddr;
  logic [BW-1:0] outBe;
  logic [DW-1:0] outWdata, outRdata;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int rrPtr;
  bit lockFlag;
  int lockedId;
  bit modelErr;
  int idQueue[$];

  typedef struct {
    logic [NrHosts-1:0] req;
    logic               gnt;
    logic               rvalid;
    logic [DW-1:0]      rdata;
    logic               expReq;
    logic [NrHosts-1:0] expGnt;
    logic [NrHosts-1:0] expRv;
    logic [AW-1:0]      expAddr;
    logic               expProtErr;
  } vec_t;

  vec_t vecs[16];
  vec_t stall[7];
  vec_t rstSeq[2];
  vec_t postRst[5];

  bus_rr_arbiter #(
    .NrHosts(NrHosts), .MaxOutstanding(MaxOut), .DataWidth(DW), .AddressWidth(AW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(hostReq), .host_gnt_o(hostGnt), .host_addr_i(hostAddr),
    .host_we_i(hostWe), .host_be_i(hostBe), .host_wdata_i(hostWdata),
    .host_rvalid_o(hostRvalid), .host_rdata_o(hostRdata), .host_err_o(hostErr),
    .out_req_o(outReq), .out_gnt_i(outGnt), .out_addr_o(outAddr),
    .out_we_o(outWe), .out_be_o(outBe), .out_wdata_o(outWdata),
    .out_rvalid_i(outRvalid), .out_rdata_i(outRdata), .out_err_i(outErr),
    .protocol_err_o(protErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NrHosts-1:0] req, input logic gnt,
                               input logic rvalid, input logic [DW-1:0] rdata, input logic err);
    for (int i = 0; i < NrHosts; i++) hostReq[i] = req[i];
    outGnt    = gnt;
    outRvalid = rvalid;
    outRdata  = rdata;
    outErr    = err;
  endtask

  function automatic logic [NrHosts-1:0] gntVec();
    logic [NrHosts-1:0] v;
    for (int i = 0; i < NrHosts; i++) v[i] = hostGnt[i];
    return v;
  endfunction

  function automatic logic [NrHosts-1:0] rvVec();
    logic [NrHosts-1:0] v;
    for (int i = 0; i < NrHosts; i++) v[i] = hostRvalid[i];
    return v;
  endfunction

  task automatic runVec(input string tag, input vec_t v);
    @(negedge clk);
    applyStimulus(v.req, v.gnt, v.rvalid, v.rdata, 1'b0);
    #1;
    checkOutput({tag, " out_req"}, 64'(outReq), 64'(v.expReq));
    checkOutput({tag, " host_gnt"}, 64'(gntVec()), 64'(v.expGnt));
    checkOutput({tag, " host_rvalid"}, 64'(rvVec()), 64'(v.expRv));
    checkOutput({tag, " out_addr"}, 64'(outAddr), 64'(v.expAddr));
    for (int i = 0; i < NrHosts; i++)
      checkOutput($sformatf("%s host_rdata[%0d]", tag, i), 64'(hostRdata[i]),
                  v.expRv[i] ? 64'(v.rdata) : 64'd0);
    checkOutput({tag, " protocol_err"}, 64'(protErr), 64'(v.expProtErr));
  endtask

  task automatic resetDut(input string tag);
    @(negedge clk);
    applyStimulus('0, 1'b0, 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput({tag, " rst out_req"}, 64'(outReq), 64'd0);
    checkOutput({tag, " rst host_gnt"}, 64'(gntVec()), 64'd0);
    checkOutput({tag, " rst host_rvalid"}, 64'(rvVec()), 64'd0);
    checkOutput({tag, " rst out_addr"}, 64'(outAddr), 64'd0);
    checkOutput({tag, " rst protocol_err"}, 64'(protErr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rrPtr = 0; lockFlag = 0; lockedId = 0; modelErr = 0;
    idQueue.delete();
  endtask

  // One cycle of the reference model: check the DUT against the rules for
  // the current inputs, then advance model state as the clock edge would.
  task automatic modelCycle(input int cyc);
    bit any = 0;
    int sel = 0;
    bit expReq, pop;
    int head = -1;
    string t = $sformatf("rnd[%0d]", cyc);
    for (int i = 0; i < NrHosts; i++) any |= hostReq[i];
    if (lockFlag) sel = lockedId;
    else begin
      for (int i = NrHosts - 1; i >= 0; i--)
        if (hostReq[(rrPtr + i) % NrHosts]) sel = (rrPtr + i) % NrHosts;
    end
    expReq = (any || lockFlag) && (idQueue.size() < MaxOut);
    pop = outRvalid && (idQueue.size() > 0);
    if (pop) head = idQueue[0];
    checkOutput({t, " out_req"}, 64'(outReq), 64'(expReq));
    checkOutput({t, " out_addr"}, 64'(outAddr), expReq ? 64'(hostAddr[sel]) : 64'd0);
    checkOutput({t, " out_we"}, 64'(outWe), expReq ? 64'(hostWe[sel]) : 64'd0);
    checkOutput({t, " out_be"}, 64'(outBe), expReq ? 64'(hostBe[sel]) : 64'd0);
    checkOutput({t, " out_wdata"}, 64'(outWdata), expReq ? 64'(hostWdata[sel]) : 64'd0);
    checkOutput({t, " protocol_err"}, 64'(protErr), 64'(modelErr));
    for (int i = 0; i < NrHosts; i++) begin
      checkOutput($sformatf("%s gnt[%0d]", t, i), 64'(hostGnt[i]), 64'(expReq && outGnt && sel == i));
      checkOutput($sformatf("%s rvalid[%0d]", t, i), 64'(hostRvalid[i]), 64'(head == i));
      checkOutput($sformatf("%s rdata[%0d]", t, i), 64'(hostRdata[i]), (head == i) ? 64'(outRdata) : 64'd0);
      checkOutput($sformatf("%s err[%0d]", t, i), 64'(hostErr[i]), 64'((head == i) && outErr));
    end
    if (outRvalid && idQueue.size() == 0) modelErr = 1;
    if (pop) void'(idQueue.pop_front());
    if (expReq && outGnt) begin
      idQueue.push_back(sel);
      rrPtr = (sel + 1) % NrHosts;
      lockFlag = 0;
    end else if (expReq) begin
      lockFlag = 1;
      lockedId = sel;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    applyStimulus('0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < NrHosts; i++) begin
      hostAddr[i] = '0; hostWe[i] = 1'b0; hostBe[i] = '0; hostWdata[i] = '0;
    end

    // Lone request, fairness, then full-FIFO back-pressure
    //          req    gnt   rv    rdata         req   gnt    rv     addr         perr
    vecs[0]  = '{2'b10, 1'b1, 1'b0, 32'h0,        1'b1, 2'b10, 2'b00, 32'h2000, 1'b0};
    vecs[1]  = '{2'b00, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 2'b00, 2'b10, 32'h0,    1'b0};
    vecs[2]  = '{2'b11, 1'b1, 1'b0, 32'h102,      1'b1, 2'b01, 2'b00, 32'h1000, 1'b0};
    vecs[3]  = '{2'b11, 1'b1, 1'b1, 32'h103,      1'b1, 2'b10, 2'b01, 32'h2000, 1'b0};
    vecs[4]  = '{2'b11, 1'b1, 1'b1, 32'h104,      1'b1, 2'b01, 2'b10, 32'h1000, 1'b0};
    vecs[5]  = '{2'b11, 1'b1, 1'b1, 32'h105,      1'b1, 2'b10, 2'b01, 32'h2000, 1'b0};
    vecs[6]  = '{2'b11, 1'b1, 1'b1, 32'h106,      1'b1, 2'b01, 2'b10, 32'h1000, 1'b0};
    vecs[7]  = '{2'b11, 1'b1, 1'b1, 32'h107,      1'b1, 2'b10, 2'b01, 32'h2000, 1'b0};
    vecs[8]  = '{2'b00, 1'b0, 1'b1, 32'h108,      1'b0, 2'b00, 2'b10, 32'h0,    1'b0};
    vecs[9]  = '{2'b11, 1'b1, 1'b0, 32'h109,      1'b1, 2'b01, 2'b00, 32'h1000, 1'b0};
    vecs[10] = '{2'b11, 1'b1, 1'b0, 32'h10A,      1'b1, 2'b10, 2'b00, 32'h2000, 1'b0};
    vecs[11] = '{2'b11, 1'b1, 1'b0, 32'h10B,      1'b0, 2'b00, 2'b00, 32'h0,    1'b0};
    vecs[12] = '{2'b11, 1'b1, 1'b1, 32'h10C,      1'b0, 2'b00, 2'b01, 32'h0,    1'b0};
    vecs[13] = '{2'b11, 1'b1, 1'b0, 32'h10D,      1'b1, 2'b01, 2'b00, 32'h1000, 1'b0};
    vecs[14] = '{2'b00, 1'b0, 1'b1, 32'h10E,      1'b0, 2'b00, 2'b10, 32'h0,    1'b0};
    vecs[15] = '{2'b00, 1'b0, 1'b1, 32'h10F,      1'b0, 2'b00, 2'b01, 32'h0,    1'b0};

    // Stall lock: host 0 held while downstream stalls, host 1 joins late
    stall[0] = '{2'b01, 1'b0, 1'b0, 32'h0,  1'b1, 2'b00, 2'b00, 32'hA0, 1'b0};
    stall[1] = '{2'b01, 1'b0, 1'b0, 32'h0,  1'b1, 2'b00, 2'b00, 32'hA0, 1'b0};
    stall[2] = '{2'b11, 1'b0, 1'b0, 32'h0,  1'b1, 2'b00, 2'b00, 32'hA0, 1'b0};
    stall[3] = '{2'b11, 1'b1, 1'b0, 32'h0,  1'b1, 2'b01, 2'b00, 32'hA0, 1'b0};
    stall[4] = '{2'b10, 1'b1, 1'b0, 32'h0,  1'b1, 2'b10, 2'b00, 32'hB0, 1'b0};
    stall[5] = '{2'b00, 1'b0, 1'b1, 32'h55, 1'b0, 2'b00, 2'b01, 32'h0,  1'b0};
    stall[6] = '{2'b00, 1'b0, 1'b1, 32'h66, 1'b0, 2'b00, 2'b10, 32'h0,  1'b0};

    // Two outstanding IDs from host 0, leaving the pointer at host 1
    rstSeq[0] = '{2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, 32'hA0, 1'b0};
    rstSeq[1] = '{2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, 32'hA0, 1'b0};

    // After reset: stale response is orphaned, error sticks, pointer is 0
    postRst[0] = '{2'b00, 1'b0, 1'b1, 32'h77, 1'b0, 2'b00, 2'b00, 32'h0,  1'b0};
    postRst[1] = '{2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 2'b00, 32'h0,  1'b1};
    postRst[2] = '{2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 2'b00, 32'h0,  1'b1};
    postRst[3] = '{2'b11, 1'b1, 1'b0, 32'h0,  1'b1, 2'b01, 2'b00, 32'hA0, 1'b1};
    postRst[4] = '{2'b00, 1'b0, 1'b1, 32'h88, 1'b0, 2'b00, 2'b01, 32'h0,  1'b1};

    #2;
    resetDut("init");

    hostAddr[0] = 32'h1000;
    hostAddr[1] = 32'h2000;
    for (int k = 0; k < 16; k++) runVec($sformatf("tbl[%0d]", k), vecs[k]);

    resetDut("stall");
    hostAddr[0] = 32'hA0;
    hostAddr[1] = 32'hB0;
    for (int k = 0; k < 7; k++) runVec($sformatf("stall[%0d]", k), stall[k]);

    resetDut("pre-mid");
    for (int k = 0; k < 2; k++) runVec($sformatf("busy[%0d]", k), rstSeq[k]);
    resetDut("mid-op");
    for (int k = 0; k < 5; k++) runVec($sformatf("postrst[%0d]", k), postRst[k]);

    resetDut("random");
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < NrHosts; i++) begin
        hostReq[i]   = ($urandom_range(0, 2) != 0);
        hostAddr[i]  = $urandom;
        hostWe[i]    = $urandom_range(0, 1) == 1;
        hostBe[i]    = BW'($urandom);
        hostWdata[i] = $urandom;
      end
      outGnt    = ($urandom_range(0, 3) != 0);
      outRvalid = ((idQueue.size() > 0) && ($urandom_range(0, 2) != 0)) || ($urandom_range(0, 99) == 0);
      outRdata  = $urandom;
      outErr    = ($urandom_range(0, 7) == 0);
      #1;
      modelCycle(c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
